// File: rtl/tcu_fedp_seq.sv
// Issue/retire sequencer around the TCU fused dot-product unit: chains per-tag
// partial sums through c_val, tracks tokens across the fixed latency, emits results.
module tcu_fedp_seq #(
    parameter int N        = 1,
    parameter int LATENCY  = 31,
    parameter int NUM_TAGS = 4,
    parameter int TAGW     = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAGW-1:0]   in_tag,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [3:0]        in_fmt_s,
    input  logic [N*32-1:0]   in_a_row,
    input  logic [N*32-1:0]   in_b_col,
    input  logic [31:0]       in_c_init,
    output logic              fedp_enable,
    output logic [3:0]        fedp_fmt_s,
    output logic [N*32-1:0]   fedp_a_row,
    output logic [N*32-1:0]   fedp_b_col,
    output logic [31:0]       fedp_c_val,
    input  logic [31:0]       fedp_d_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAGW-1:0]   out_tag,
    output logic [31:0]       out_data,
    output logic              busy
);

    logic [LATENCY-1:0]  tok_valid;
    logic [LATENCY-1:0]  tok_last;
    logic [TAGW-1:0]     tok_tag [LATENCY];
    logic [NUM_TAGS-1:0] pending;
    logic [31:0]         acc [NUM_TAGS];

    logic            stall;
    logic            fire;
    logic            retire;
    logic            bypass_hit;
    logic            tail_valid;
    logic            tail_last;
    logic [TAGW-1:0] tail_tag;
    logic [31:0]     c_sel;

    assign stall       = out_valid && !out_ready;
    assign fedp_enable = !stall;

    assign tail_valid = tok_valid[LATENCY-1];
    assign tail_last  = tok_last[LATENCY-1];
    assign tail_tag   = tok_tag[LATENCY-1];

    // The retiring partial sum can feed the next chunk of the same tag directly,
    // so a chained tag issues on its retire cycle instead of one cycle later.
    assign bypass_hit = tail_valid && !tail_last && (tail_tag == in_tag);
    assign in_ready   = fedp_enable && (!pending[in_tag] || bypass_hit);
    assign fire       = in_valid && in_ready;
    assign retire     = fedp_enable && tail_valid;

    always_comb begin
        c_sel = acc[in_tag];
        if (in_first) begin
            c_sel = in_c_init;
        end else if (bypass_hit) begin
            c_sel = fedp_d_val;
        end
    end

    assign fedp_fmt_s = in_fmt_s;
    assign fedp_a_row = fire ? in_a_row : '0;
    assign fedp_b_col = fire ? in_b_col : '0;
    assign fedp_c_val = fire ? c_sel : '0;

    assign busy = (|tok_valid) || out_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tok_valid <= '0;
            tok_last  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tok_tag[i] <= '0;
            end
        end else if (fedp_enable) begin
            tok_valid[0] <= fire;
            tok_last[0]  <= in_last;
            tok_tag[0]   <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                tok_valid[i] <= tok_valid[i-1];
                tok_last[i]  <= tok_last[i-1];
                tok_tag[i]   <= tok_tag[i-1];
            end
        end
    end

    // Set after clear so a same-tag issue on the retire cycle stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            if (retire) begin
                pending[tail_tag] <= 1'b0;
            end
            if (fire) begin
                pending[in_tag] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                acc[i] <= '0;
            end
        end else if (retire && !tail_last) begin
            acc[tail_tag] <= fedp_d_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (retire && tail_last) begin
                out_valid <= 1'b1;
                out_tag   <= tail_tag;
                out_data  <= fedp_d_val;
            end
        end
    end

endmodule

// File: doc/tcu_fedp_seq.md
Name: tcu_fedp_seq

Overview:
- Issue/retire sequencer that sits directly upstream and downstream of the TCU fused dot-product (FEDP) unit.
- Accepts a stream of dot-product chunks (N packed 32-bit operand words per side). Each chunk belongs to one of NUM_TAGS independent accumulations.
- Chains partial sums back into the FEDP c_val input per tag, tracks in-flight tokens across the fixed FEDP latency, and emits final results with valid/ready.
- Drives the FEDP enable so output backpressure freezes the whole datapath.

Parameters:
- N, 1, packed 32-bit words per FEDP operand row/column (matches FEDP N).
- LATENCY, 31, FEDP enabled-cycle latency from input sample to d_val.
- NUM_TAGS, 4, independent accumulation contexts.
- TAGW, $clog2(NUM_TAGS) (min 1), tag width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  chunk valid.
- in_ready  out  1  chunk accepted when in_valid && in_ready (fire).
- in_tag  in  TAGW  accumulation context.
- in_first  in  1  first chunk of tag: use in_c_init as c.
- in_last  in  1  final chunk: result goes to output.
- in_fmt_s  in  4  source format id (FP16/BF16).
- in_a_row  in  N*32  packed A operands.
- in_b_col  in  N*32  packed B operands.
- in_c_init  in  32  FP32 initial accumulator.
- fedp_enable  out  1  FEDP pipeline enable.
- fedp_fmt_s  out  4  to FEDP fmt_s.
- fedp_a_row  out  N*32  to FEDP a_row.
- fedp_b_col  out  N*32  to FEDP b_col.
- fedp_c_val  out  32  to FEDP c_val.
- fedp_d_val  in  32  FEDP result.
- out_valid  out  1  final result valid.
- out_ready  in  1  consumer ready.
- out_tag  out  TAGW  tag of result.
- out_data  out  32  FP32 result.
- busy  out  1  any token in flight or out_valid.

Behaviour:
- stall = out_valid && !out_ready; fedp_enable = !stall.
- in_ready = fedp_enable && (!pending[in_tag] || bypass_hit).
  - bypass_hit = tail token valid, !last, tag == in_tag.
  - in_ready combinationally depends on out_ready; this path is accepted.
- On fire: fedp_a_row/b_col = inputs, fedp_fmt_s = in_fmt_s, fedp_c_val = c_sel. Otherwise a_row/b_col/c_val are driven 0 and fmt_s passes through.
- c_sel, in priority order:
  - in_first → in_c_init;
  - bypass_hit → fedp_d_val;
  - otherwise acc[in_tag].
- Token pipe: LATENCY stages of {valid, tag, last}. It shifts only when fedp_enable=1.
  - Stage 0 gets {fire, in_tag, in_last}.
  - The tail token is aligned with fedp_d_val in the same cycle.
- Retire happens when fedp_enable && tail valid:
  - non-last: acc[tag] <= fedp_d_val.
  - last: out_tag/out_data <= tail tag/fedp_d_val and out_valid <= 1. No overflow is possible because retire requires !stall.
  - Either case clears pending[tag].
- pending[in_tag] is set on fire; it is held per tag, so a tag has at most 1 chunk in flight.
  - Same-cycle set (fire) and clear (retire, same tag) → pending ends 1.
- out_valid clears on out_valid && out_ready unless a last retire reloads it in the same cycle.
- A non-first chunk on an idle tag uses the stored acc (0 after reset); no error is flagged.
- While stalled: all tokens, acc, pending and out regs hold; fedp_enable=0 freezes FEDP.
- Reset (async, reset_n=0): all token valids 0, pending 0, acc 0, out_valid 0, out_tag 0, out_data 0.
  - Tokens in flight are discarded. FEDP internal data is ignored because its tokens are gone.
- busy = OR of token valids | out_valid.
- Latency: last-chunk fire at edge t → out_valid at edge t+LATENCY, given no stall.

Test Plan:
1. Single chunk, tag 2, first=last=1, fmt FP16, a=0x3C003C00, b=0x40004000, c_init=0x3F800000 → out_valid exactly 31 cycles after fire, out_tag=2, out_data=0x40A00000 (5.0).
2. Tag 0, 3 chunks of a=0x3C003C00, b=0x40004000, c_init=0 → in_ready low 30 cycles between fires; each next fire occurs on the retire cycle via bypass; out_data=0x41400000 (12.0).
3. Tags 0..3 round-robin, 2 chunks each, distinct c_init 1.0/2.0/3.0/4.0 with a, b as in 1 → four results 0x41100000, 0x41200000, 0x41300000, 0x41400000, in last-issue order, no cross-tag corruption.
4. Hold out_ready=0 while 2 results pending → fedp_enable=0 and in_ready=0 while out_valid; out_data stable. Raise out_ready → second result follows with no loss or duplication.
5. Assert reset_n low with 3 tokens in flight and out_valid=1 → out_valid=0 and busy=0 immediately; after release in_ready=1 and no stale result emerges within 40 cycles.
6. Present tag 1 non-first chunk while tag 1 pending and tag 3 chunk behind it → tag 1 blocked (in_ready=0) until retire cycle. In-order stream: tag 3 does not bypass.
